// File: rtl/turn_pkg.sv
// Shared types and constants for the two-player turn scheduler.
package turn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        SWAP = 2'b11
    } sched_state_t;

    localparam logic P_J1  = 1'b0;
    localparam logic P_J2  = 1'b1;
    localparam int   SEC_W = 6;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    // clear dominates so a pending wrap can never leak out as a tick
    assign tick = en && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Alternates turns between two players with a per-turn seconds countdown.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TURN_SECONDS  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_player,
    input  logic             move_done,
    input  logic             pause,
    input  logic             game_over,
    output logic             turn,
    output logic [SEC_W-1:0] sec_left,
    output logic             finished,
    output logic             swap,
    output logic [1:0]       sched_state
);

    localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(TURN_SECONDS);

    sched_state_t     state, state_nx;
    logic             turn_nx, finished_nx, swap_nx;
    logic [SEC_W-1:0] sec_nx;
    logic             pre_clear, pre_en, tick;

    assign pre_clear   = game_over || (state != RUN);
    assign pre_en      = (state == RUN) && !pause;
    assign sched_state = state;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(pre_clear),
        .en   (pre_en),
        .tick (tick)
    );

    // swap is raised on the edge leaving SWAP, so it always trails finished
    always_comb begin
        state_nx    = state;
        turn_nx     = turn;
        sec_nx      = sec_left;
        finished_nx = 1'b0;
        swap_nx     = 1'b0;
        if (game_over) begin
            state_nx = IDLE;
            sec_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    sec_nx = '0;
                    if (start) begin
                        turn_nx  = first_player;
                        state_nx = LOAD;
                    end
                end
                LOAD: begin
                    sec_nx   = SEC_LOAD;
                    state_nx = RUN;
                end
                RUN: begin
                    if (!pause) begin
                        // a move on the final-tick cycle wins over the timeout
                        if (move_done) begin
                            state_nx = SWAP;
                        end else if (tick && (sec_left != '0)) begin
                            sec_nx = sec_left - 1'b1;
                            if (sec_left == SEC_W'(1)) begin
                                finished_nx = 1'b1;
                                state_nx    = SWAP;
                            end
                        end
                    end
                end
                SWAP: begin
                    swap_nx  = 1'b1;
                    turn_nx  = ~turn;
                    state_nx = LOAD;
                end
                default: begin
                    state_nx = IDLE;
                    sec_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turn     <= P_J1;
            sec_left <= '0;
            finished <= 1'b0;
            swap     <= 1'b0;
        end else begin
            turn     <= turn_nx;
            sec_left <= sec_nx;
            finished <= finished_nx;
            swap     <= swap_nx;
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a pulse scoreboard (4 clk per second, 3 s turns).
module tb_turn_scheduler;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_SWAP = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, first_player, move_done, pause, game_over;
    logic       turn, finished, swap;
    logic [5:0] sec_left;
    logic [1:0] sched_state;

    typedef struct {
        bit is_swap;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  cyc = 0;
    int  n_assert = 0;
    int  n_fail = 0;
    int  r;

    turn_scheduler #(
        .TICKS_PER_SEC(4),
        .TURN_SECONDS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_player(first_player),
        .move_done   (move_done),
        .pause       (pause),
        .game_over   (game_over),
        .turn        (turn),
        .sec_left    (sec_left),
        .finished    (finished),
        .swap        (swap),
        .sched_state (sched_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic t, input logic [5:0] s);
        chk({tag, "_state"}, 32'(sched_state), 32'(st));
        chk({tag, "_turn"}, 32'(turn), 32'(t));
        chk({tag, "_sec"}, 32'(sec_left), 32'(s));
    endtask

    task automatic expect_pulse(input bit is_swap, input int c);
        ev_t e;
        e.is_swap = is_swap;
        e.cyc     = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every finished/swap pulse must match the next scheduled expectation.
    always @(negedge clk) begin
        if (finished === 1'b1 || swap === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({swap, finished}), 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk(mon_ev.is_swap ? "pulse_kind_swap" : "pulse_kind_finished",
                    32'({swap, finished}), mon_ev.is_swap ? 32'd2 : 32'd1);
                chk("pulse_cycle", 32'(cyc), 32'(mon_ev.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0; first_player = 1'b0; move_done = 1'b0; pause = 1'b0; game_over = 1'b0;
        step(2);
        expect_out("reset", S_IDLE, 1'b0, 6'd0);
        chk("reset_finished", 32'(finished), 32'd0);
        chk("reset_swap", 32'(swap), 32'd0);
        rst = 1'b1;
        step(3);
        chk("idle_hold", 32'(sched_state), 32'(S_IDLE));

        // timeout with J1 first
        start = 1'b1; first_player = 1'b0;
        step(1);
        expect_out("load1", S_LOAD, 1'b0, 6'd0);
        start = 1'b0;
        step(1);
        r = cyc;
        expect_out("run1", S_RUN, 1'b0, 6'd3);
        expect_pulse(1'b0, r + 12);
        expect_pulse(1'b1, r + 13);
        step(11);
        expect_out("to_last", S_RUN, 1'b0, 6'd1);
        step(1);
        expect_out("to_fin", S_SWAP, 1'b0, 6'd0);
        chk("to_fin_pulse", 32'(finished), 32'd1);
        chk("to_fin_noswap", 32'(swap), 32'd0);
        step(1);
        expect_out("to_swap", S_LOAD, 1'b1, 6'd0);
        chk("to_swap_pulse", 32'(swap), 32'd1);
        step(1);
        r = cyc;
        expect_out("to_rerun", S_RUN, 1'b1, 6'd3);

        // move five cycles into the turn
        step(5);
        move_done = 1'b1;
        expect_pulse(1'b1, r + 7);
        step(1);
        move_done = 1'b0;
        expect_out("mv_swapst", S_SWAP, 1'b1, 6'd2);
        chk("mv_nofin", 32'(finished), 32'd0);
        step(1);
        expect_out("mv_load", S_LOAD, 1'b0, 6'd2);
        chk("mv_swap_pulse", 32'(swap), 32'd1);
        step(1);
        r = cyc;
        expect_out("mv_rerun", S_RUN, 1'b0, 6'd3);

        // move_done on the final-tick cycle
        step(11);
        expect_out("col_last", S_RUN, 1'b0, 6'd1);
        move_done = 1'b1;
        expect_pulse(1'b1, r + 13);
        step(1);
        move_done = 1'b0;
        expect_out("col_swapst", S_SWAP, 1'b0, 6'd1);
        chk("col_nofin", 32'(finished), 32'd0);
        step(1);
        expect_out("col_load", S_LOAD, 1'b1, 6'd1);
        step(1);
        r = cyc;
        expect_out("col_rerun", S_RUN, 1'b1, 6'd3);

        // pause for seven cycles with an ignored move inside it
        step(5);
        expect_out("pz_enter", S_RUN, 1'b1, 6'd2);
        pause = 1'b1;
        step(2);
        move_done = 1'b1;
        step(1);
        move_done = 1'b0;
        expect_out("pz_move_ignored", S_RUN, 1'b1, 6'd2);
        step(4);
        expect_out("pz_hold", S_RUN, 1'b1, 6'd2);
        pause = 1'b0;
        expect_pulse(1'b0, r + 19);
        expect_pulse(1'b1, r + 20);
        step(6);
        expect_out("pz_last", S_RUN, 1'b1, 6'd1);
        step(1);
        expect_out("pz_fin", S_SWAP, 1'b1, 6'd0);
        step(2);
        r = cyc;
        expect_out("pz_rerun", S_RUN, 1'b0, 6'd3);

        // start held in RUN is ignored, then game_over aborts
        start = 1'b1; first_player = 1'b1;
        step(3);
        expect_out("start_in_run", S_RUN, 1'b0, 6'd3);
        game_over = 1'b1; move_done = 1'b1;
        step(1);
        game_over = 1'b0; move_done = 1'b0; start = 1'b0;
        expect_out("abort", S_IDLE, 1'b0, 6'd0);
        chk("abort_nofin", 32'(finished), 32'd0);
        chk("abort_noswap", 32'(swap), 32'd0);
        step(2);
        chk("abort_idle", 32'(sched_state), 32'(S_IDLE));

        // J2 first, then asynchronous reset mid-turn
        start = 1'b1; first_player = 1'b1;
        step(1);
        expect_out("j2_load", S_LOAD, 1'b1, 6'd0);
        start = 1'b0;
        step(1);
        expect_out("j2_run", S_RUN, 1'b1, 6'd3);
        step(9);
        expect_out("j2_mid", S_RUN, 1'b1, 6'd1);
        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst", S_IDLE, 1'b0, 6'd0);
        chk("async_rst_fin", 32'(finished), 32'd0);
        chk("async_rst_swap", 32'(swap), 32'd0);
        step(2);
        expect_out("rst_held", S_IDLE, 1'b0, 6'd0);
        rst = 1'b1;
        step(3);
        expect_out("post_rst", S_IDLE, 1'b0, 6'd0);

        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
